energy_ctrl_multi: RTL and testbench

Control FSM for the energy monitor datapath. It generalises the single-job IDLE/COMPUTE controller in four ways:
- an internal, run-time configurable weight-beat counter replaces the external counter-ready input;
- a channel tag travels from spin to energy result;
- an explicit pipeline-drain phase is parameterised by PIPESMID;
- it adds a back-to-back mode and single-step debug.

It sits between the host stream interfaces (config/spin/weight/energy) and the energy compute datapath.

---
 rtl/energy_ctrl_pkg.sv | 8 +
 rtl/energy_ctrl_multi_if.sv | 39 +++
 rtl/energy_beat_counter.sv | 19 +
 rtl/energy_ctrl_multi.sv | 83 ++++++++
 tb/tb_energy_ctrl_multi.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/energy_ctrl_pkg.sv
// energy_ctrl_pkg: shared types and width helper for the energy monitor controller
package energy_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUTPUT} state_t;
    typedef enum logic {SINGLE = 1'b0, B2B = 1'b1} mode_t;
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/energy_ctrl_multi_if.sv
// energy_ctrl_multi_if: host stream and datapath signals of the energy controller
interface energy_ctrl_multi_if
    import energy_ctrl_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 10
);
    localparam int CH_W = width_of(NUM_CH);
    logic             en_i;
    logic             config_valid_i;
    logic             config_ready_o;
    logic [CNT_W-1:0] config_beats_i;
    logic             config_mode_i;
    logic             spin_valid_i;
    logic             spin_ready_o;
    logic [CH_W-1:0]  spin_ch_i;
    logic             weight_valid_i;
    logic             weight_ready_o;
    logic             cmpt_done_i;
    logic             energy_valid_o;
    logic             energy_ready_i;
    logic [CH_W-1:0]  energy_ch_o;
    logic             busy_o;
    logic [CNT_W-1:0] beat_cnt_o;
    logic             debug_en_i;
    logic             debug_step_i;
    modport slave (
        input  en_i, config_valid_i, config_beats_i, config_mode_i, spin_valid_i, spin_ch_i,
               weight_valid_i, cmpt_done_i, energy_ready_i, debug_en_i, debug_step_i,
        output config_ready_o, spin_ready_o, weight_ready_o, energy_valid_o, energy_ch_o,
               busy_o, beat_cnt_o
    );
    modport master (
        output en_i, config_valid_i, config_beats_i, config_mode_i, spin_valid_i, spin_ch_i,
               weight_valid_i, cmpt_done_i, energy_ready_i, debug_en_i, debug_step_i,
        input  config_ready_o, spin_ready_o, weight_ready_o, energy_valid_o, energy_ch_o,
               busy_o, beat_cnt_o
    );
endinterface

// File: rtl/energy_beat_counter.sv
// energy_beat_counter: weight-beat up-counter with last-beat detect; a programmed count of 0 means 2^CNT_W
module energy_beat_counter #(
    parameter int CNT_W = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] beats_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o
);
    assign last_o = cnt_o == beats_i - CNT_W'(1);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_o <= '0;
        else if (clr_i) cnt_o <= '0;
        else if (inc_i) cnt_o <= cnt_o + CNT_W'(1);
    end
endmodule

// File: rtl/energy_ctrl_multi.sv
// energy_ctrl_multi: job controller for the energy datapath with beat counting,
// pipeline drain, channel tagging, back-to-back mode and single-step debug
module energy_ctrl_multi
    import energy_ctrl_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int CNT_W         = 10,
    parameter int PIPESMID      = 1,
    parameter int NUM_BEATS_DEF = 256
) (
    input logic                clk_i,
    input logic                rst_i,
    energy_ctrl_multi_if.slave bus
);
    localparam int CH_W = width_of(NUM_CH);
    localparam int DR_W = width_of(PIPESMID + 1);
    state_t           state, state_n;
    mode_t            mode_reg;
    logic [CNT_W-1:0] beats_reg;
    logic [CH_W-1:0]  tag, energy_ch;
    logic [DR_W-1:0]  drain;
    logic             energy_valid, last, act, dbg;
    logic             cfg_hs, spin_hs, w_hs, energy_hs;
    assign act = bus.en_i && !rst_i;
    assign dbg = bus.debug_en_i;
    assign bus.config_ready_o = act && !dbg && state == IDLE;
    assign bus.spin_ready_o   = act && !dbg && ((state == IDLE && !bus.config_valid_i) ||
                                (state == OUTPUT && mode_reg == B2B && bus.energy_ready_i));
    assign bus.weight_ready_o = act && state == LOAD && (!dbg || bus.debug_step_i);
    assign cfg_hs    = bus.config_valid_i && bus.config_ready_o;
    assign spin_hs   = bus.spin_valid_i && bus.spin_ready_o;
    assign w_hs      = bus.weight_valid_i && bus.weight_ready_o;
    assign energy_hs = act && energy_valid && bus.energy_ready_i;
    assign bus.energy_valid_o = energy_valid;
    assign bus.energy_ch_o    = energy_ch;
    assign bus.busy_o         = state != IDLE;
    energy_beat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (spin_hs),
        .inc_i  (w_hs),
        .beats_i(beats_reg),
        .cnt_o  (bus.beat_cnt_o),
        .last_o (last)
    );
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else state <= state_n;
    end
    // A result consumed under debug leaves OUTPUT only once debug is released
    always_comb begin
        state_n = state;
        if (bus.en_i)
            case (state)
                IDLE:    state_n = spin_hs ? LOAD : IDLE;
                LOAD:    state_n = (w_hs && last) ? DRAIN : LOAD;
                DRAIN:   state_n = (!dbg && drain == '0 && bus.cmpt_done_i) ? OUTPUT : DRAIN;
                default: state_n = (!dbg && (energy_hs || !energy_valid)) ? (spin_hs ? LOAD : IDLE) : OUTPUT;
            endcase
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beats_reg    <= CNT_W'(NUM_BEATS_DEF);
            mode_reg     <= SINGLE;
            tag          <= '0;
            drain        <= '0;
            energy_valid <= 1'b0;
            energy_ch    <= '0;
        end else if (bus.en_i) begin
            if (cfg_hs) begin
                beats_reg <= bus.config_beats_i;
                mode_reg  <= mode_t'(bus.config_mode_i);
            end
            if (spin_hs) tag <= bus.spin_ch_i;
            if (w_hs && last) drain <= DR_W'(PIPESMID);
            else if (state == DRAIN && drain != '0 && !dbg) drain <= drain - DR_W'(1);
            if (state == DRAIN && state_n == OUTPUT) begin
                energy_valid <= 1'b1;
                energy_ch    <= tag;
            end else if (energy_hs) energy_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_energy_ctrl_multi.sv
// tb_energy_ctrl_multi: directed stimulus with a tag scoreboard checked by a negedge monitor
module tb_energy_ctrl_multi;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int beats_seen = 0;
    logic [1:0] exp_q[$];
    energy_ctrl_multi_if #(.NUM_CH(4), .CNT_W(10)) ifc ();
    energy_ctrl_multi dut (.clk_i(clk), .rst_i(rst), .bus(ifc));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask
    // Handshakes are sampled mid-cycle, where inputs and outputs are settled
    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.weight_valid_i && ifc.weight_ready_o) beats_seen++;
            if (ifc.energy_valid_o && ifc.energy_ready_i && ifc.en_i) begin
                if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
                else chk("result_ch", 32'(ifc.energy_ch_o), 32'(exp_q.pop_front()));
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic cfg(input int beats, input logic mode);
        ifc.config_valid_i = 1'b1;
        ifc.config_beats_i = 10'(beats);
        ifc.config_mode_i  = mode;
        tick();
        ifc.config_valid_i = 1'b0;
    endtask
    task automatic spin(input logic [1:0] ch);
        ifc.spin_valid_i = 1'b1;
        ifc.spin_ch_i    = ch;
        exp_q.push_back(ch);
        tick();
        ifc.spin_valid_i = 1'b0;
    endtask
    task automatic run_beats(input string name, input int base, input int exp, input int budget);
        ifc.weight_valid_i = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!ifc.weight_ready_o) break;
        end
        ifc.weight_valid_i = 1'b0;
        chk(name, beats_seen - base, exp);
    endtask
    task automatic wait_valid(input string name, input int budget);
        for (int i = 0; i < budget && !ifc.energy_valid_o; i++) tick();
        chk(name, 32'(ifc.energy_valid_o), 1);
    endtask
    task automatic consume();
        ifc.energy_ready_i = 1'b1;
        tick();
        ifc.energy_ready_i = 1'b0;
    endtask
    initial begin
        int base;
        logic seen;
        ifc.en_i = 1'b1;
        ifc.config_valid_i = 1'b0;
        ifc.config_beats_i = '0;
        ifc.config_mode_i = 1'b0;
        ifc.spin_valid_i = 1'b0;
        ifc.spin_ch_i = '0;
        ifc.weight_valid_i = 1'b0;
        ifc.cmpt_done_i = 1'b1;
        ifc.energy_ready_i = 1'b0;
        ifc.debug_en_i = 1'b0;
        ifc.debug_step_i = 1'b0;
        tick();
        tick();
        chk("rst_config_ready", 32'(ifc.config_ready_o), 0);
        chk("rst_spin_ready", 32'(ifc.spin_ready_o), 0);
        chk("rst_weight_ready", 32'(ifc.weight_ready_o), 0);
        chk("rst_valid", 32'(ifc.energy_valid_o), 0);
        chk("rst_ch", 32'(ifc.energy_ch_o), 0);
        chk("rst_busy", 32'(ifc.busy_o), 0);
        chk("rst_beat_cnt", 32'(ifc.beat_cnt_o), 0);
        rst = 1'b0;
        #1;
        chk("idle_config_ready", 32'(ifc.config_ready_o), 1);
        chk("idle_spin_ready", 32'(ifc.spin_ready_o), 1);
        // default single-shot job, 256 beats, PIPESMID=1
        base = beats_seen;
        spin(2'd2);
        chk("t1_busy", 32'(ifc.busy_o), 1);
        run_beats("t1_beats", base, 256, 300);
        chk("t1_beat_cnt", 32'(ifc.beat_cnt_o), 256);
        chk("t1_valid_c0", 32'(ifc.energy_valid_o), 0);
        tick();
        chk("t1_valid_c1", 32'(ifc.energy_valid_o), 0);
        tick();
        chk("t1_valid_c2", 32'(ifc.energy_valid_o), 1);
        chk("t1_ch", 32'(ifc.energy_ch_o), 2);
        repeat (3) tick();
        chk("t1_valid_held", 32'(ifc.energy_valid_o), 1);
        consume();
        chk("t1_valid_drop", 32'(ifc.energy_valid_o), 0);
        chk("t1_busy_end", 32'(ifc.busy_o), 0);
        // config has priority over spin; beats=0 means 1024
        ifc.config_valid_i = 1'b1;
        ifc.config_beats_i = '0;
        ifc.config_mode_i = 1'b0;
        ifc.spin_valid_i = 1'b1;
        ifc.spin_ch_i = 2'd1;
        #1;
        chk("t2_config_ready", 32'(ifc.config_ready_o), 1);
        chk("t2_spin_blocked", 32'(ifc.spin_ready_o), 0);
        tick();
        ifc.config_valid_i = 1'b0;
        chk("t2_busy_after_cfg", 32'(ifc.busy_o), 0);
        base = beats_seen;
        spin(2'd1);
        run_beats("t2_beats", base, 1024, 1100);
        chk("t2_beat_cnt", 32'(ifc.beat_cnt_o), 0);
        wait_valid("t2_wait", 20);
        consume();
        // back-to-back: new spin rides on the energy handshake
        cfg(4, 1'b1);
        base = beats_seen;
        spin(2'd1);
        run_beats("t3_beats_a", base, 4, 20);
        wait_valid("t3_wait_a", 20);
        ifc.energy_ready_i = 1'b1;
        ifc.spin_valid_i = 1'b1;
        ifc.spin_ch_i = 2'd3;
        #1;
        chk("t3_spin_ready", 32'(ifc.spin_ready_o), 1);
        exp_q.push_back(2'd3);
        tick();
        ifc.energy_ready_i = 1'b0;
        ifc.spin_valid_i = 1'b0;
        chk("t3_busy", 32'(ifc.busy_o), 1);
        chk("t3_load", 32'(ifc.weight_ready_o), 1);
        chk("t3_beat_cnt", 32'(ifc.beat_cnt_o), 0);
        chk("t3_valid_drop", 32'(ifc.energy_valid_o), 0);
        base = beats_seen;
        run_beats("t3_beats_b", base, 4, 20);
        wait_valid("t3_wait_b", 20);
        chk("t3_ch_b", 32'(ifc.energy_ch_o), 3);
        consume();
        chk("t3_idle", 32'(ifc.busy_o), 0);
        // debug single-step
        cfg(8, 1'b0);
        base = beats_seen;
        spin(2'd0);
        ifc.weight_valid_i = 1'b1;
        repeat (3) tick();
        ifc.debug_en_i = 1'b1;
        #1;
        chk("t4_frozen_ready", 32'(ifc.weight_ready_o), 0);
        repeat (3) tick();
        chk("t4_cnt_frozen", 32'(ifc.beat_cnt_o), 3);
        for (int i = 0; i < 5; i++) begin
            ifc.debug_step_i = 1'b1;
            tick();
            ifc.debug_step_i = 1'b0;
            tick();
        end
        ifc.weight_valid_i = 1'b0;
        chk("t4_beats", beats_seen - base, 8);
        chk("t4_beat_cnt", 32'(ifc.beat_cnt_o), 8);
        repeat (5) tick();
        chk("t4_drain_hold", 32'(ifc.energy_valid_o), 0);
        ifc.debug_en_i = 1'b0;
        wait_valid("t4_wait", 10);
        ifc.debug_en_i = 1'b1;
        consume();
        chk("t4_valid_drop", 32'(ifc.energy_valid_o), 0);
        tick();
        chk("t4_busy_held", 32'(ifc.busy_o), 1);
        ifc.debug_en_i = 1'b0;
        tick();
        chk("t4_busy_end", 32'(ifc.busy_o), 0);
        // enable freeze, then late cmpt_done
        cfg(20, 1'b0);
        base = beats_seen;
        spin(2'd1);
        ifc.weight_valid_i = 1'b1;
        repeat (5) tick();
        ifc.en_i = 1'b0;
        #1;
        chk("t5_weight_gated", 32'(ifc.weight_ready_o), 0);
        repeat (10) tick();
        chk("t5_cnt_frozen", 32'(ifc.beat_cnt_o), 5);
        chk("t5_beats_frozen", beats_seen - base, 5);
        ifc.en_i = 1'b1;
        ifc.cmpt_done_i = 1'b0;
        run_beats("t5_beats", base, 20, 40);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen |= ifc.energy_valid_o;
        end
        chk("t5_no_early_valid", 32'(seen), 0);
        ifc.cmpt_done_i = 1'b1;
        chk("t5_valid_before", 32'(ifc.energy_valid_o), 0);
        tick();
        chk("t5_valid_after", 32'(ifc.energy_valid_o), 1);
        chk("t5_ch", 32'(ifc.energy_ch_o), 1);
        // async reset during OUTPUT drops the pending result
        #1 rst = 1'b1;
        #1;
        chk("t6_valid_async", 32'(ifc.energy_valid_o), 0);
        chk("t6_busy_async", 32'(ifc.busy_o), 0);
        #1 rst = 1'b0;
        exp_q.delete();
        tick();
        base = beats_seen;
        spin(2'd3);
        run_beats("t6_default_beats", base, 256, 300);
        wait_valid("t6_wait", 20);
        consume();
        chk("t6_idle", 32'(ifc.busy_o), 0);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
